// File: rtl/vga_axil_pkg.sv
// ---------------------------------------------------------------------------
// vga_axil_pkg
// Shared native-side types for the VGA AXI-Lite slave and the register
// blocks that sit behind it.
//   axil_data_t   : 32-bit data word carried on the native bus
//   native_addr_t : default 3-bit native word address
// ---------------------------------------------------------------------------
package vga_axil_pkg;

    localparam int AXIL_DATA_W          = 32;
    localparam int NATIVE_ADDR_W_DEFAULT = 3;

    typedef logic [AXIL_DATA_W-1:0]           axil_data_t;
    typedef logic [NATIVE_ADDR_W_DEFAULT-1:0] native_addr_t;

endpackage

// File: rtl/vga_csr_pkg.sv
// ---------------------------------------------------------------------------
// vga_csr_pkg
// Register map, field positions, timing-config struct, reset defaults and
// the apply-state encoding for the VGA control/status register block.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_csr_pkg;

    localparam int REG_ADDR_W = 3;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ADDR_CTRL   = 3'd0;
    localparam reg_addr_t ADDR_HTIM   = 3'd1;
    localparam reg_addr_t ADDR_HSYNC  = 3'd2;
    localparam reg_addr_t ADDR_VTIM   = 3'd3;
    localparam reg_addr_t ADDR_VSYNC  = 3'd4;
    localparam reg_addr_t ADDR_STATUS = 3'd5;
    localparam reg_addr_t ADDR_IRQ    = 3'd6;
    localparam reg_addr_t ADDR_IRQ_EN = 3'd7;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_APPLY_BIT  = 31;

    // Timing registers hold two 12-bit fields, low half and high half
    localparam int FIELD_W      = 12;
    localparam int FIELD_LO_LSB = 0;
    localparam int FIELD_HI_LSB = 16;

    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_ENABLE_BIT  = 1;
    localparam int STATUS_FCNT_LSB    = 16;
    localparam int STATUS_FCNT_W      = 16;

    localparam int IRQ_W              = 2;
    localparam int IRQ_FRAME_DONE_BIT = 0;
    localparam int IRQ_APPLY_DONE_BIT = 1;

    typedef logic [FIELD_W-1:0] timing_field_t;

    typedef struct packed {
        logic          enable;
        timing_field_t h_active;
        timing_field_t h_total;
        timing_field_t hsync_start;
        timing_field_t hsync_end;
        timing_field_t v_active;
        timing_field_t v_total;
        timing_field_t vsync_start;
        timing_field_t vsync_end;
    } vga_timing_cfg_t;

    localparam vga_timing_cfg_t VGA_CFG_640X480 = '{
        enable:      1'b0,
        h_active:    12'd640,
        h_total:     12'd800,
        hsync_start: 12'd656,
        hsync_end:   12'd752,
        v_active:    12'd480,
        v_total:     12'd525,
        vsync_start: 12'd490,
        vsync_end:   12'd492
    };

    typedef enum logic {
        APPLY_IDLE,
        APPLY_PENDING
    } apply_state_e;

    // Builds the read-back view of a timing register from its two fields
    function automatic logic [31:0] pack_pair(input timing_field_t lo,
                                              input timing_field_t hi);
        return {4'b0, hi, 4'b0, lo};
    endfunction

endpackage

// File: rtl/vga_csr_ctrl.sv
// ---------------------------------------------------------------------------
// vga_csr_ctrl
// Control/status registers for the VGA timing generator. Software writes a
// staging bank; an apply request copies it into the shadow bank (which
// drives cfg_o) at the next frame boundary, or immediately if the
// generator is stopped. Also keeps a frame counter and a maskable IRQ.
//
// Ports:
//   clk_i         system clock
//   arst_n_i      asynchronous active-low reset
//   addr_write_i  native write word address
//   data_i        native write data
//   write_en_i    native write strobe
//   addr_read_i   native read word address
//   read_en_i     native read strobe
//   data_o        registered read data, held until the next read
//   frame_start_i one-cycle start-of-frame pulse from the timing generator
//   cfg_o         shadow timing configuration (incl. enable)
//   irq_o         level interrupt = |(IRQ & IRQ_EN)
// ---------------------------------------------------------------------------
module vga_csr_ctrl
    import vga_axil_pkg::*;
    import vga_csr_pkg::*;
#(
    parameter int NATIVE_ADDR_W = 3,
    parameter int FRAME_CNT_W   = 16
) (
    input  logic                     clk_i,
    input  logic                     arst_n_i,
    input  logic [NATIVE_ADDR_W-1:0] addr_write_i,
    input  axil_data_t               data_i,
    input  logic                     write_en_i,
    input  logic [NATIVE_ADDR_W-1:0] addr_read_i,
    input  logic                     read_en_i,
    output axil_data_t               data_o,
    input  logic                     frame_start_i,
    output vga_timing_cfg_t          cfg_o,
    output logic                     irq_o
);

    logic                   wr_in_range;
    logic                   rd_in_range;
    reg_addr_t              wr_idx;
    reg_addr_t              rd_idx;
    logic [7:0]             wr_sel;
    logic                   apply_req;
    logic                   copy_ready;
    logic                   do_copy;
    logic                   pending;
    logic                   frame_tick;
    apply_state_e           state;
    apply_state_e           state_next;
    vga_timing_cfg_t        staging;
    vga_timing_cfg_t        shadow;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [IRQ_W-1:0]       irq;
    logic [IRQ_W-1:0]       irq_en;
    logic [IRQ_W-1:0]       irq_clear;
    logic [IRQ_W-1:0]       irq_set;
    axil_data_t             rd_data;
    logic                   unused_data_bits;

    // Reserved data bits are intentionally dropped
    assign unused_data_bits = ^{data_i[30:28], data_i[15:12]};

    // Any address bit above the 8-register window makes the access a no-op
    assign wr_in_range = ((addr_write_i >> REG_ADDR_W) == '0);
    assign rd_in_range = ((addr_read_i >> REG_ADDR_W) == '0);
    assign wr_idx      = addr_write_i[REG_ADDR_W-1:0];
    assign rd_idx      = addr_read_i[REG_ADDR_W-1:0];

    always_comb begin
        wr_sel = '0;
        if (write_en_i && wr_in_range) begin
            wr_sel[wr_idx] = 1'b1;
        end
    end

    assign apply_req = wr_sel[ADDR_CTRL] && data_i[CTRL_APPLY_BIT];

    // A stopped generator never sends frame_start_i, so don't wait for it
    assign copy_ready = !shadow.enable || frame_start_i;

    // Frames only count while the generator is actually running
    assign frame_tick = frame_start_i && shadow.enable;

    // Apply FSM: state register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= APPLY_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Apply FSM: next state. An apply seen in IDLE only arms the request,
    // so a coincident frame_start_i does not trigger the copy.
    always_comb begin
        state_next = state;
        unique case (state)
            APPLY_IDLE:    if (apply_req)  state_next = APPLY_PENDING;
            APPLY_PENDING: if (copy_ready) state_next = APPLY_IDLE;
            default:                       state_next = APPLY_IDLE;
        endcase
    end

    // Apply FSM: outputs
    always_comb begin
        pending = 1'b0;
        do_copy = 1'b0;
        if (state == APPLY_PENDING) begin
            pending = 1'b1;
            do_copy = copy_ready;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            staging <= VGA_CFG_640X480;
        end else begin
            if (wr_sel[ADDR_CTRL]) begin
                staging.enable <= data_i[CTRL_ENABLE_BIT];
            end
            if (wr_sel[ADDR_HTIM]) begin
                staging.h_active <= data_i[FIELD_LO_LSB +: FIELD_W];
                staging.h_total  <= data_i[FIELD_HI_LSB +: FIELD_W];
            end
            if (wr_sel[ADDR_HSYNC]) begin
                staging.hsync_start <= data_i[FIELD_LO_LSB +: FIELD_W];
                staging.hsync_end   <= data_i[FIELD_HI_LSB +: FIELD_W];
            end
            if (wr_sel[ADDR_VTIM]) begin
                staging.v_active <= data_i[FIELD_LO_LSB +: FIELD_W];
                staging.v_total  <= data_i[FIELD_HI_LSB +: FIELD_W];
            end
            if (wr_sel[ADDR_VSYNC]) begin
                staging.vsync_start <= data_i[FIELD_LO_LSB +: FIELD_W];
                staging.vsync_end   <= data_i[FIELD_HI_LSB +: FIELD_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            shadow <= VGA_CFG_640X480;
        end else if (do_copy) begin
            shadow <= staging;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

    // Hardware set is applied after the W1C clear so a same-cycle event wins
    assign irq_clear = wr_sel[ADDR_IRQ] ? data_i[IRQ_W-1:0] : '0;

    always_comb begin
        irq_set                     = '0;
        irq_set[IRQ_FRAME_DONE_BIT] = frame_tick;
        irq_set[IRQ_APPLY_DONE_BIT] = do_copy;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            irq    <= '0;
            irq_en <= '0;
        end else begin
            irq <= (irq & ~irq_clear) | irq_set;
            if (wr_sel[ADDR_IRQ_EN]) begin
                irq_en <= data_i[IRQ_W-1:0];
            end
        end
    end

    // Read mux uses current register contents, so a same-cycle write to the
    // same address is not visible until the next read
    always_comb begin
        rd_data = '0;
        if (rd_in_range) begin
            unique case (rd_idx)
                ADDR_CTRL:   rd_data[CTRL_ENABLE_BIT] = staging.enable;
                ADDR_HTIM:   rd_data = pack_pair(staging.h_active, staging.h_total);
                ADDR_HSYNC:  rd_data = pack_pair(staging.hsync_start, staging.hsync_end);
                ADDR_VTIM:   rd_data = pack_pair(staging.v_active, staging.v_total);
                ADDR_VSYNC:  rd_data = pack_pair(staging.vsync_start, staging.vsync_end);
                ADDR_STATUS: begin
                    rd_data[STATUS_PENDING_BIT] = pending;
                    rd_data[STATUS_ENABLE_BIT]  = shadow.enable;
                    rd_data[STATUS_FCNT_LSB +: STATUS_FCNT_W] = STATUS_FCNT_W'(frame_cnt);
                end
                ADDR_IRQ:    rd_data[IRQ_W-1:0] = irq;
                ADDR_IRQ_EN: rd_data[IRQ_W-1:0] = irq_en;
                default:     rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            data_o <= '0;
        end else if (read_en_i) begin
            data_o <= rd_data;
        end
    end

    assign cfg_o = shadow;
    assign irq_o = |(irq & irq_en);

endmodule

// File: tb/tb_vga_csr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_csr_ctrl
// Self-checking bench for vga_csr_ctrl: a table of directed register
// accesses, hand-written apply/IRQ/reset sequences, then random traffic,
// all compared every cycle against a word-level reference model.
// ---------------------------------------------------------------------------
module tb_vga_csr_ctrl;
    import vga_csr_pkg::*;

    logic            clk_i         = 1'b0;
    logic            arst_n_i      = 1'b0;
    logic [2:0]      addr_write_i  = '0;
    logic [31:0]     data_i        = '0;
    logic            write_en_i    = 1'b0;
    logic [2:0]      addr_read_i   = '0;
    logic            read_en_i     = 1'b0;
    logic [31:0]     data_o;
    logic            frame_start_i = 1'b0;
    vga_timing_cfg_t cfg_o;
    logic            irq_o;

    vga_csr_ctrl #(
        .NATIVE_ADDR_W(3),
        .FRAME_CNT_W  (16)
    ) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .addr_write_i (addr_write_i),
        .data_i       (data_i),
        .write_en_i   (write_en_i),
        .addr_read_i  (addr_read_i),
        .read_en_i    (read_en_i),
        .data_o       (data_o),
        .frame_start_i(frame_start_i),
        .cfg_o        (cfg_o),
        .irq_o        (irq_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: register words as software sees them
    logic [31:0] m_stg [1:4];
    logic [31:0] m_sh  [1:4];
    logic        m_stg_en;
    logic        m_sh_en;
    logic        m_pending;
    logic [1:0]  m_irq;
    logic [1:0]  m_irq_en;
    int unsigned m_fcnt;
    logic [31:0] m_data;

    localparam logic [96:0] DEFAULT_CFG = {1'b0, 12'd640, 12'd800, 12'd656, 12'd752,
                                           12'd480, 12'd525, 12'd490, 12'd492};

    task automatic modelReset();
        m_stg[1] = 32'h0320_0280;
        m_stg[2] = 32'h02F0_0290;
        m_stg[3] = 32'h020D_01E0;
        m_stg[4] = 32'h01EC_01EA;
        for (int i = 1; i <= 4; i++) m_sh[i] = m_stg[i];
        m_stg_en  = 1'b0;
        m_sh_en   = 1'b0;
        m_pending = 1'b0;
        m_irq     = '0;
        m_irq_en  = '0;
        m_fcnt    = 0;
        m_data    = '0;
    endtask

    function automatic logic [31:0] modelRead(input int a);
        case (a)
            0:       return {31'd0, m_stg_en};
            1, 2, 3, 4: return m_stg[a];
            5:       return {m_fcnt[15:0], 14'd0, m_sh_en, m_pending};
            6:       return {30'd0, m_irq};
            7:       return {30'd0, m_irq_en};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [96:0] expCfg();
        return {m_sh_en,
                m_sh[1][11:0], m_sh[1][27:16], m_sh[2][11:0], m_sh[2][27:16],
                m_sh[3][11:0], m_sh[3][27:16], m_sh[4][11:0], m_sh[4][27:16]};
    endfunction

    // One clock of register behaviour, all decisions made from pre-edge state
    task automatic modelStep(input logic we, input int wa, input logic [31:0] wd,
                             input logic re, input int ra, input logic fs);
        logic copy;
        logic tick;
        logic apply;
        if (re) m_data = modelRead(ra);
        copy  = m_pending && (!m_sh_en || fs);
        tick  = fs && m_sh_en;
        apply = we && (wa == 0) && wd[31];
        if (we && wa == 6) m_irq = m_irq & ~wd[1:0];
        if (tick) m_irq[0] = 1'b1;
        if (copy) begin
            m_irq[1] = 1'b1;
            for (int i = 1; i <= 4; i++) m_sh[i] = m_stg[i];
            m_sh_en = m_stg_en;
        end
        if (tick) m_fcnt = (m_fcnt + 1) % 65536;
        if (we) begin
            case (wa)
                0:          m_stg_en = wd[0];
                1, 2, 3, 4: m_stg[wa] = wd & 32'h0FFF_0FFF;
                7:          m_irq_en = wd[1:0];
                default:    ;
            endcase
        end
        m_pending = copy ? 1'b0 : (m_pending || apply);
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drives one cycle of stimulus and advances the model in step with the DUT
    task automatic applyStimulus(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                                 input logic re, input logic [2:0] ra, input logic fs);
        write_en_i    = we;
        addr_write_i  = wa;
        data_i        = wd;
        read_en_i     = re;
        addr_read_i   = ra;
        frame_start_i = fs;
        @(posedge clk_i);
        modelStep(we, int'(wa), wd, re, int'(ra), fs);
        @(negedge clk_i);
        write_en_i    = 1'b0;
        read_en_i     = 1'b0;
        frame_start_i = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        check($sformatf("%s data_o", tag), data_o, m_data);
        check($sformatf("%s cfg_o", tag), cfg_o, expCfg());
        check($sformatf("%s irq_o", tag), irq_o, |(m_irq & m_irq_en));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b0);
            checkOutput("idle");
        end
    endtask

    task automatic readExpect(input string name, input logic [2:0] ra, input logic [31:0] exp);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, ra, 1'b0);
        check(name, data_o, exp);
        checkOutput(name);
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Directed table: every row also reads, exp is data_o after the edge
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd0, 32'h0000_0000});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd1, 32'h0320_0280});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd2, 32'h02F0_0290});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd3, 32'h020D_01E0});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd4, 32'h01EC_01EA});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd5, 32'h0000_0000});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd6, 32'h0000_0000});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd7, 32'h0000_0000});
        vecs.push_back('{1'b1, 3'd5, 32'hFFFF_FFFF, 3'd5, 32'h0000_0000});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd5, 32'h0000_0000});
        vecs.push_back('{1'b1, 3'd2, 32'hFFFF_FFFF, 3'd2, 32'h02F0_0290});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd2, 32'h0FFF_0FFF});
        vecs.push_back('{1'b1, 3'd2, 32'h02F0_0290, 3'd7, 32'h0000_0000});
        vecs.push_back('{1'b1, 3'd1, 32'h0420_0320, 3'd1, 32'h0320_0280});
        vecs.push_back('{1'b0, 3'd0, 32'h0, 3'd1, 32'h0420_0320});
        vecs.push_back('{1'b1, 3'd0, 32'h8000_0001, 3'd0, 32'h0000_0000});

        modelReset();
        repeat (3) @(negedge clk_i);
        check("reset cfg_o", cfg_o, DEFAULT_CFG);
        check("reset data_o", data_o, 32'd0);
        check("reset irq_o", irq_o, 1'b0);
        arst_n_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, 1'b1, vecs[i].ra, 1'b0);
            check($sformatf("vec%0d data_o", i), data_o, vecs[i].exp);
            checkOutput($sformatf("vec%0d", i));
        end

        // Stopped generator: copy lands the cycle after the apply write
        idle(1);
        check("stopped apply h_active", cfg_o.h_active, 12'h320);
        check("stopped apply enable", cfg_o.enable, 1'b1);
        readExpect("stopped apply IRQ", 3'd6, 32'h2);
        applyStimulus(1'b1, 3'd6, 32'h2, 1'b0, 3'd0, 1'b0);
        checkOutput("clear irq");

        // Running generator: apply waits for frame_start_i
        applyStimulus(1'b1, 3'd1, 32'h0400_0300, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd0, 32'h8000_0001, 1'b0, 3'd0, 1'b0);
        idle(50);
        check("wait h_active", cfg_o.h_active, 12'h320);
        readExpect("wait STATUS", 3'd5, 32'h0000_0003);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b1);
        check("frame apply h_active", cfg_o.h_active, 12'h300);
        checkOutput("frame apply");
        readExpect("after apply STATUS", 3'd5, 32'h0001_0002);

        // Apply coincident with frame_start_i is deferred to the next frame
        applyStimulus(1'b1, 3'd1, 32'h0400_0200, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd0, 32'h8000_0001, 1'b0, 3'd0, 1'b1);
        check("coincident no copy", cfg_o.h_active, 12'h300);
        idle(3);
        readExpect("coincident STATUS", 3'd5, 32'h0002_0003);
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b1);
        check("deferred copy h_active", cfg_o.h_active, 12'h200);
        checkOutput("deferred copy");

        // Frame IRQ, masking and W1C-vs-set priority
        applyStimulus(1'b1, 3'd7, 32'h1, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd6, 32'h3, 1'b0, 3'd0, 1'b0);
        check("irq cleared", irq_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b1);
            checkOutput("frame pulse");
        end
        check("frame irq", irq_o, 1'b1);
        readExpect("three frames STATUS", 3'd5, 32'h0006_0002);
        applyStimulus(1'b1, 3'd6, 32'h1, 1'b0, 3'd0, 1'b1);
        readExpect("set beats clear", 3'd6, 32'h1);
        check("set beats clear irq_o", irq_o, 1'b1);
        applyStimulus(1'b1, 3'd6, 32'h1, 1'b0, 3'd0, 1'b0);
        check("final clear irq_o", irq_o, 1'b0);

        // Asynchronous reset while an apply is pending
        applyStimulus(1'b1, 3'd1, 32'h0111_0222, 1'b0, 3'd0, 1'b0);
        applyStimulus(1'b1, 3'd0, 32'h8000_0001, 1'b0, 3'd0, 1'b0);
        idle(2);
        readExpect("pending before reset", 3'd5, 32'h0007_0003);
        #2;
        arst_n_i = 1'b0;
        #1;
        check("mid reset cfg_o", cfg_o, DEFAULT_CFG);
        check("mid reset data_o", data_o, 32'd0);
        check("mid reset irq_o", irq_o, 1'b0);
        modelReset();
        @(negedge clk_i);
        arst_n_i = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 1'b1, 3'd5, 1'b1);
        check("post reset STATUS", data_o, 32'd0);
        check("post reset no copy", cfg_o, DEFAULT_CFG);
        idle(2);
        check("post reset still default", cfg_o, DEFAULT_CFG);
        readExpect("post reset HTIM", 3'd1, 32'h0320_0280);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                          1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 5) == 0));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
